// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: payload, valid and sideband with load/hold/bubble/flush control,
// plus saturating bubble and hold cycle counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       SIDE_W     = 1,
  parameter int unsigned       STALL_W    = 6,
  parameter int unsigned       STAGE      = 2,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic [SIDE_W-1:0]  in_side,
  input  logic               cnt_clr,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [SIDE_W-1:0]  out_side,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  if (STAGE + 2 > STALL_W) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
  end
  if (DATA_W < 1 || SIDE_W < 1 || CNT_W < 2) begin : g_bad_width
    $error("pipe_stage_reg: DATA_W/SIDE_W must be >= 1 and CNT_W >= 2");
  end

  typedef enum logic [1:0] {ActFlush, ActBubble, ActAdvance, ActHold} action_e;

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [SIDE_W-1:0] side_q, side_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic              s0, s1;
  action_e           act;

  assign s0 = stall[STAGE];
  assign s1 = stall[STAGE+1];

  // Only this boundary's two stall bits matter; the rest belong to other stages.
  logic unused_stall;
  assign unused_stall = ^stall;

  always_comb begin
    act = ActHold;
    if (flush)         act = ActFlush;
    else if (s0 && !s1) act = ActBubble;
    else if (!s0)      act = ActAdvance;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    side_d  = side_q;
    unique case (act)
      ActFlush: begin
        data_d  = BUBBLE_VAL;
        valid_d = 1'b0;
        side_d  = '0;
      end
      ActBubble: begin
        data_d  = BUBBLE_VAL;
        valid_d = 1'b0;
      end
      ActAdvance: begin
        data_d  = in_valid ? in_data : BUBBLE_VAL;
        valid_d = in_valid;
        side_d  = in_side;
      end
      default: ;
    endcase
  end

  // Counters saturate at all-ones; a clear wins over any increment on the same edge.
  always_comb begin
    bubble_d = bubble_q;
    hold_d   = hold_q;
    if (cnt_clr) begin
      bubble_d = '0;
      hold_d   = '0;
    end else begin
      if (act == ActBubble && bubble_q != '1) bubble_d = bubble_q + CNT_W'(1);
      if (act == ActHold && hold_q != '1)     hold_d   = hold_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= BUBBLE_VAL;
      valid_q  <= 1'b0;
      side_q   <= '0;
      bubble_q <= '0;
      hold_q   <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      side_q   <= side_d;
      bubble_q <= bubble_d;
      hold_q   <= hold_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_side   = side_q;
  assign bubble_cnt = bubble_q;
  assign hold_cnt   = hold_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a behavioural model;
// a second instance with CNT_W=2 exercises counter saturation.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [63:0] in_data;
  logic        in_valid;
  logic [0:0]  in_side;
  logic        cnt_clr;

  logic [63:0] out_data, s_out_data;
  logic        out_valid, s_out_valid;
  logic [0:0]  out_side, s_out_side;
  logic [15:0] bubble_cnt, hold_cnt;
  logic [1:0]  s_bubble_cnt, s_hold_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the outputs must be after the most recent edge.
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_side;
  int          m_bub, m_hold, m_sbub, m_shold;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(64), .SIDE_W(1), .STALL_W(6), .STAGE(2), .BUBBLE_VAL(64'h0), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_side(in_side), .cnt_clr(cnt_clr), .out_data(out_data),
    .out_valid(out_valid), .out_side(out_side), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  pipe_stage_reg #(
    .DATA_W(64), .SIDE_W(1), .STALL_W(6), .STAGE(2), .BUBBLE_VAL(64'h0), .CNT_W(2)
  ) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_side(in_side), .cnt_clr(cnt_clr), .out_data(s_out_data),
    .out_valid(s_out_valid), .out_side(s_out_side), .bubble_cnt(s_bubble_cnt),
    .hold_cnt(s_hold_cnt)
  );

  task automatic model_reset();
    m_data = 64'h0; m_valid = 1'b0; m_side = 1'b0;
    m_bub = 0; m_hold = 0; m_sbub = 0; m_shold = 0;
  endtask

  // One edge of the priority rules: flush > bubble (s0&!s1) > advance (!s0) > hold.
  task automatic model_edge();
    bit s0, s1, is_bub, is_hold;
    s0 = stall[2]; s1 = stall[3];
    is_bub = 0; is_hold = 0;
    if (flush) begin
      m_data = 64'h0; m_valid = 1'b0; m_side = 1'b0;
    end else if (s0 && !s1) begin
      m_data = 64'h0; m_valid = 1'b0; is_bub = 1;
    end else if (!s0) begin
      m_valid = in_valid; m_side = in_side[0]; m_data = in_valid ? in_data : 64'h0;
    end else begin
      is_hold = 1;
    end
    if (cnt_clr) begin
      m_bub = 0; m_hold = 0; m_sbub = 0; m_shold = 0;
    end else begin
      if (is_bub)  begin m_bub  = (m_bub  < 65535) ? m_bub + 1  : m_bub;
                         m_sbub = (m_sbub < 3)     ? m_sbub + 1 : m_sbub; end
      if (is_hold) begin m_hold  = (m_hold  < 65535) ? m_hold + 1  : m_hold;
                         m_shold = (m_shold < 3)     ? m_shold + 1 : m_shold; end
    end
  endtask

  // Advance one edge and leave time 1 unit past it for sampling/driving.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
  endtask

  task automatic drive(input logic [5:0] st, input logic fl, input logic [63:0] d,
                       input logic v, input logic sd, input logic clr);
    stall = st; flush = fl; in_data = d; in_valid = v; in_side = sd; cnt_clr = clr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(6'($urandom), 1'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom),
            1'($urandom));
      step();
      n_tests++;
      if ({out_data, out_valid, out_side, bubble_cnt, hold_cnt} !== 98'h0) begin
        n_fail++;
        $display("FAIL reset_held: data=%h v=%b s=%b bub=%0d hold=%0d, required all zero",
                 out_data, out_valid, out_side, bubble_cnt, hold_cnt);
      end
    end
    rst = 1'b0;
    // Build up nonzero state, then assert reset between edges.
    drive(6'b000000, 0, 64'hABCD, 1, 1, 0); step();
    drive(6'b000111, 0, 64'h0, 0, 0, 0);    step();
    drive(6'b001111, 0, 64'h0, 0, 0, 0);    step();
    drive(6'b000000, 0, 64'h1234, 1, 1, 0); step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if ({out_data, out_valid, out_side, bubble_cnt, hold_cnt} !== 98'h0) begin
      n_fail++;
      $display("FAIL reset_async: data=%h v=%b s=%b bub=%0d hold=%0d, required all zero",
               out_data, out_valid, out_side, bubble_cnt, hold_cnt);
    end
    step();
    rst = 1'b0;
    drive(6'b000000, 0, 64'h55, 1, 1, 0);
    step();
    n_tests++;
    if (out_data !== 64'h55 || out_valid !== 1'b1 || out_side !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_edge: data=%h v=%b s=%b, required 55/1/1",
               out_data, out_valid, out_side);
    end
  endtask

  task automatic test_advance();
    drive(6'b000000, 0, 64'hDEAD_BEEF_0123_4567, 1, 1, 0);
    step();
    n_tests++;
    if (out_data !== 64'hDEAD_BEEF_0123_4567 || out_valid !== 1'b1 || out_side !== 1'b1) begin
      n_fail++;
      $display("FAIL advance_load: data=%h v=%b s=%b, required deadbeef01234567/1/1",
               out_data, out_valid, out_side);
    end
    drive(6'b000000, 0, 64'hFFFF_0000_FFFF_0000, 0, 0, 0);
    step();
    n_tests++;
    if (out_data !== 64'h0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL advance_invalid: data=%h v=%b, required 0/0", out_data, out_valid);
    end
  endtask

  task automatic test_bubble();
    drive(6'b000000, 0, {$urandom, $urandom}, 1, 1, 1);
    step();
    drive(6'b000111, 0, 64'h77, 1, 0, 0);
    repeat (3) step();
    n_tests++;
    if (out_data !== 64'h0 || out_valid !== 1'b0 || out_side !== 1'b1 ||
        bubble_cnt !== 16'd3 || hold_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL bubble: data=%h v=%b s=%b bub=%0d hold=%0d, required 0/0/1/3/0",
               out_data, out_valid, out_side, bubble_cnt, hold_cnt);
    end
  endtask

  task automatic test_hold();
    drive(6'b000000, 0, 64'h1, 1, 1, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(6'b001111, 0, {$urandom, $urandom}, 1'($urandom), 0, 0);
      step();
      n_tests++;
      if (out_data !== 64'h1 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_data[%0d]: data=%h v=%b, required 1/1", i, out_data, out_valid);
      end
    end
    n_tests++;
    if (hold_cnt !== 16'd5 || bubble_cnt !== 16'd0 || s_hold_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL hold_cnt: hold=%0d bub=%0d small_hold=%0d, required 5/0/3",
               hold_cnt, bubble_cnt, s_hold_cnt);
    end
  endtask

  task automatic test_flush();
    drive(6'b001111, 1, 64'h99, 1, 1, 0);
    step();
    n_tests++;
    if ({out_data, out_valid, out_side} !== 66'h0 || hold_cnt !== 16'd5 ||
        bubble_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL flush_stalled: data=%h v=%b s=%b bub=%0d hold=%0d, required 0/0/0/0/5",
               out_data, out_valid, out_side, bubble_cnt, hold_cnt);
    end
    drive(6'b000000, 0, 64'h42, 1, 1, 0);
    step();
    drive(6'b000000, 1, 64'h43, 1, 1, 0);
    step();
    n_tests++;
    if ({out_data, out_valid, out_side} !== 66'h0 || hold_cnt !== 16'd5 ||
        bubble_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL flush_free: data=%h v=%b s=%b bub=%0d hold=%0d, required 0/0/0/0/5",
               out_data, out_valid, out_side, bubble_cnt, hold_cnt);
    end
  endtask

  task automatic test_saturation();
    drive(6'b000000, 0, 64'h0, 0, 0, 1);
    step();
    for (int i = 1; i <= 6; i++) begin
      drive(6'b000111, 0, 64'h0, 0, 0, 0);
      step();
      n_tests++;
      if (s_bubble_cnt !== 2'((i > 3) ? 3 : i)) begin
        n_fail++;
        $display("FAIL saturate[%0d]: bub=%0d, required %0d", i, s_bubble_cnt,
                 (i > 3) ? 3 : i);
      end
    end
    drive(6'b000111, 0, 64'h0, 0, 0, 1);
    step();
    n_tests++;
    if (s_bubble_cnt !== 2'd0 || bubble_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_over_bubble: small_bub=%0d bub=%0d, required 0/0",
               s_bubble_cnt, bubble_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(6'($urandom), ($urandom_range(0, 9) == 0), {$urandom, $urandom}, 1'($urandom),
            1'($urandom), ($urandom_range(0, 24) == 0));
      step();
      n_tests++;
      if (out_data !== m_data || out_valid !== m_valid || out_side !== m_side ||
          bubble_cnt !== 16'(m_bub) || hold_cnt !== 16'(m_hold) ||
          s_bubble_cnt !== 2'(m_sbub) || s_hold_cnt !== 2'(m_shold)) begin
        n_fail++;
        $display({"FAIL random[%0d]: got %h/%b/%b bub=%0d hold=%0d sb=%0d sh=%0d, ",
                  "required %h/%b/%b bub=%0d hold=%0d sb=%0d sh=%0d"}, i,
                 out_data, out_valid, out_side, bubble_cnt, hold_cnt, s_bubble_cnt, s_hold_cnt,
                 m_data, m_valid, m_side, m_bub, m_hold, m_sbub, m_shold);
      end
    end
  endtask

  initial begin
    drive(6'b0, 0, 64'h0, 0, 0, 0);
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
